// File: rtl/dma_read_engine.sv
// dma_read_engine: splits a byte-length read job into AXI4 INCR bursts that
// never cross a 4 KB page and streams the returned beats to a consumer with
// zero latency. Errors are sticky; a faulty burst drains before the job ends.
module dma_read_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [31:0]           i_total_len,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_last,
    input  logic                  i_ready
);

    localparam int PAD_W = ADDR_WIDTH - 13;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_AR,
        S_R,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             len_left_q;
    logic [ADDR_WIDTH-1:0]   araddr_q;
    logic [7:0]              arlen_q;
    logic [12:0]             btb_q;
    logic [7:0]              beat_cnt_q;
    logic                    error_q;

    logic                    start_ok;
    logic                    r_hs;
    logic                    final_beat;
    logic                    burst_end;
    logic                    beat_err;
    logic [12:0]             to_boundary;
    logic [12:0]             len_clamp;
    logic [12:0]             btb_calc;
    logic [12:0]             btb_m4;
    logic [31:0]             len_after;

    // Smaller of two 13-bit byte counts.
    function automatic logic [12:0] min13(input logic [12:0] a, input logic [12:0] b);
        return (a < b) ? a : b;
    endfunction

    // A job needs a 64-byte aligned base and a non-zero whole-word length.
    assign start_ok   = i_start && (i_base_addr[5:0] == 6'd0) &&
                        (i_total_len[1:0] == 2'd0) && (i_total_len != 32'd0);
    assign r_hs       = (state_q == S_R) && m_axi_rvalid && i_ready;
    assign final_beat = (beat_cnt_q == arlen_q);
    assign burst_end  = r_hs && final_beat;
    assign beat_err   = r_hs && ((m_axi_rresp != 2'b00) || (m_axi_rlast != final_beat));
    assign len_after  = len_left_q - {19'd0, btb_q};

    // Burst size: remaining length, capped at 1 KB (256 beats) and at the 4 KB page end.
    always_comb begin
        to_boundary = 13'd4096 - {1'b0, addr_q[11:0]};
        len_clamp   = (len_left_q > 32'd1024) ? 13'd1024 : len_left_q[12:0];
        btb_calc    = min13(len_clamp, to_boundary);
        btb_m4      = btb_calc - 13'd4;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_ok) state_d = S_CALC;
            S_CALC: state_d = S_AR;
            S_AR:   if (m_axi_arready) state_d = S_R;
            S_R: begin
                if (burst_end) begin
                    if ((len_after == 32'd0) || error_q || beat_err) state_d = S_DONE;
                    else                                              state_d = S_CALC;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Job bookkeeping: address/length, burst parameters, beat counter, sticky error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q     <= '0;
            len_left_q <= '0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            btb_q      <= '0;
            beat_cnt_q <= '0;
            error_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        addr_q     <= i_base_addr;
                        len_left_q <= i_total_len;
                        error_q    <= 1'b0;
                    end else if (i_start) begin
                        error_q    <= 1'b1;
                    end
                end
                S_CALC: begin
                    araddr_q <= addr_q;
                    arlen_q  <= 8'(btb_m4 >> 2);
                    btb_q    <= btb_calc;
                end
                S_AR: begin
                    if (m_axi_arready) beat_cnt_q <= '0;
                end
                S_R: begin
                    if (beat_err) error_q <= 1'b1;
                    if (burst_end) begin
                        addr_q     <= addr_q + {{PAD_W{1'b0}}, btb_q};
                        len_left_q <= len_after;
                    end else if (r_hs) begin
                        beat_cnt_q <= beat_cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_axi_araddr = araddr_q;
    assign m_axi_arlen  = arlen_q;
    assign o_error      = error_q;

    // Output decode: AR drive in AR_HANDSHAKE, R pass-through in R_BURST.
    always_comb begin
        o_busy        = (state_q != S_IDLE);
        o_done        = (state_q == S_DONE);
        m_axi_arvalid = 1'b0;
        m_axi_arsize  = 3'b000;
        m_axi_arburst = 2'b00;
        m_axi_rready  = 1'b0;
        o_valid       = 1'b0;
        o_data        = '0;
        o_last        = 1'b0;
        case (state_q)
            S_AR: begin
                m_axi_arvalid = 1'b1;
                m_axi_arsize  = 3'b010;
                m_axi_arburst = 2'b01;
            end
            S_R: begin
                m_axi_rready = i_ready;
                o_valid      = m_axi_rvalid;
                o_data       = m_axi_rdata;
                o_last       = m_axi_rvalid && final_beat &&
                               (len_left_q == {19'd0, btb_q});
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dma_read_engine.sv
// Bench for dma_read_engine: AXI slave model, stream scoreboard, job table.
module tb_dma_read_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [31:0] i_base_addr;
    logic [31:0] i_total_len;
    logic        o_busy, o_done, o_error;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [31:0] o_data;
    logic        o_valid, o_last;
    logic        i_ready;

    dma_read_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_total_len(i_total_len), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .o_data(o_data), .o_valid(o_valid), .o_last(o_last), .i_ready(i_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] data; logic last; } beat_t;
    typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
    typedef struct {
        string       name;
        logic [31:0] base;
        logic [31:0] len;
        bit          accept;
        int          nar;
        int          nbeats;
        bit          rnd;
        bit          ign;
    } vec_t;

    beat_t beat_q[$];
    ar_t   ar_q[$];

    int n_assert = 0;
    int n_fail   = 0;
    int n_ar_seen = 0;
    int n_beat_seen = 0;
    int beat_cyc = 0;
    bit rnd_mode = 1'b0;
    int err_beat = -1;
    bit slv_active = 1'b0;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_5A5A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference burst split: push expected ARs and beats for a whole job.
    task automatic model_job(input logic [31:0] base, input logic [31:0] len);
        logic [31:0] a;
        logic [31:0] l;
        int b;
        a = base;
        l = len;
        while (l != 0) begin
            b = 4096 - int'(a[11:0]);
            if (b > 1024) b = 1024;
            if (l < 32'(b)) b = int'(l);
            ar_q.push_back('{addr: a, len: 8'(b / 4 - 1)});
            for (int i = 0; i < b / 4; i++)
                beat_q.push_back('{data: pat(a + 32'(4 * i)),
                                   last: (l == 32'(b)) && (i == b / 4 - 1)});
            a = a + 32'(b);
            l = l - 32'(b);
        end
    endtask

    // AXI slave model: one outstanding burst, optional random stalls.
    initial begin
        bit          ar_hs_s, r_hs_s, cur_v;
        logic [31:0] cap_addr, b_addr;
        logic [7:0]  cap_len;
        int          b_n, b_i, gbeat;
        cur_v = 0; b_n = 0; b_i = 0; gbeat = 0; b_addr = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0;
        m_axi_rresp = 0; m_axi_rlast = 0; i_ready = 1;
        forever begin
            @(negedge clk);
            ar_hs_s  = m_axi_arvalid && m_axi_arready;
            r_hs_s   = m_axi_rvalid && m_axi_rready;
            cap_addr = m_axi_araddr;
            cap_len  = m_axi_arlen;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                slv_active = 0; cur_v = 0; gbeat = 0; b_i = 0;
            end else begin
                if (!o_busy) gbeat = 0;
                if (ar_hs_s) begin
                    slv_active = 1; b_addr = cap_addr; b_n = int'(cap_len) + 1; b_i = 0;
                end else if (r_hs_s) begin
                    b_i++; gbeat++;
                    if (b_i == b_n) slv_active = 0;
                end
                if (slv_active) begin
                    if (!(cur_v && !r_hs_s))
                        cur_v = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
                end else begin
                    cur_v = 0;
                end
            end
            m_axi_rvalid  = cur_v;
            m_axi_rdata   = pat(b_addr + 32'(4 * b_i));
            m_axi_rlast   = slv_active && (b_i == b_n - 1);
            m_axi_rresp   = (slv_active && gbeat == err_beat) ? 2'b10 : 2'b00;
            m_axi_arready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            i_ready       = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: AR scoreboard, R pass-through checks, stream scoreboard.
    initial begin
        ar_t   ea;
        beat_t eb;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (m_axi_arvalid && m_axi_arready) begin
                    n_ar_seen++;
                    n_assert++;
                    if (ar_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL ar_unexpected: got araddr 0x%0h with none required", m_axi_araddr);
                    end else begin
                        ea = ar_q.pop_front();
                        chk("araddr", m_axi_araddr, ea.addr);
                        chk("arlen", 32'(m_axi_arlen), 32'(ea.len));
                        chk("arsize", 32'(m_axi_arsize), 32'd2);
                        chk("arburst", 32'(m_axi_arburst), 32'd1);
                    end
                end
                if (slv_active) begin
                    chk("rready_track", 32'(m_axi_rready), 32'(i_ready));
                    chk("ovalid_track", 32'(o_valid), 32'(m_axi_rvalid));
                end
                if (o_valid && i_ready) begin
                    n_beat_seen++;
                    beat_cyc = cyc;
                    n_assert++;
                    if (beat_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL beat_unexpected: got data 0x%0h with none required", o_data);
                    end else begin
                        eb = beat_q.pop_front();
                        chk("o_data", o_data, eb.data);
                        chk("o_last", 32'(o_last), 32'(eb.last));
                    end
                end
            end
        end
    end

    task automatic pulse_start(input logic [31:0] base, input logic [31:0] len);
        i_base_addr = base;
        i_total_len = len;
        i_start = 1;
        @(posedge clk);
        #2;
        i_start = 0;
    endtask

    task automatic finish_job(input string nm, input int ar0, input int b0, input int exp_nar,
                              input int exp_nbeats, input bit exp_err, input bit ign);
        bit got;
        int done_cyc;
        got = 0;
        done_cyc = 0;
        for (int k = 0; k < 6000 && !got; k++) begin
            @(posedge clk);
            #2;
            if (ign && k == 20) begin
                i_base_addr = 32'h2000; i_total_len = 32'd64; i_start = 1;
            end else begin
                i_start = 0;
            end
            if (o_done) begin
                got = 1;
                done_cyc = cyc;
            end
        end
        i_start = 0;
        chk({nm, "_done_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({nm, "_done_latency"}, done_cyc, beat_cyc + 1);
            @(posedge clk);
            #2;
            chk({nm, "_done_width"}, 32'(o_done), 32'd0);
            chk({nm, "_idle_busy"}, 32'(o_busy), 32'd0);
        end
        chk({nm, "_ar_count"}, n_ar_seen - ar0, exp_nar);
        chk({nm, "_beat_count"}, n_beat_seen - b0, exp_nbeats);
        chk({nm, "_error"}, 32'(o_error), 32'(exp_err));
        chk({nm, "_beats_left"}, beat_q.size(), 0);
        chk({nm, "_ars_left"}, ar_q.size(), 0);
    endtask

    task automatic run_job(input vec_t v);
        int  ar0, b0;
        bit  busy_seen, arv_seen;
        ar0 = n_ar_seen;
        b0  = n_beat_seen;
        rnd_mode = v.rnd;
        if (v.accept) model_job(v.base, v.len);
        pulse_start(v.base, v.len);
        if (!v.accept) begin
            busy_seen = o_busy;
            arv_seen  = m_axi_arvalid;
            repeat (5) begin
                @(posedge clk);
                #2;
                busy_seen |= o_busy;
                arv_seen  |= m_axi_arvalid;
            end
            chk({v.name, "_error"}, 32'(o_error), 32'd1);
            chk({v.name, "_busy"}, 32'(busy_seen), 32'd0);
            chk({v.name, "_arvalid"}, 32'(arv_seen), 32'd0);
            chk({v.name, "_ar_count"}, n_ar_seen - ar0, 0);
        end else begin
            finish_job(v.name, ar0, b0, v.nar, v.nbeats, 1'b0, v.ign);
        end
    endtask

    initial begin
        vec_t vecs[8];
        int   ar0, b0;

        rst_n = 0; i_start = 0; i_base_addr = 0; i_total_len = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_arvalid", 32'(m_axi_arvalid), 32'd0);
        chk("rst_error", 32'(o_error), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        rst_n = 1;
        @(posedge clk);
        #2;

        vecs[0] = '{name: "single_burst", base: 32'h1000, len: 32'd64,   accept: 1, nar: 1, nbeats: 16,  rnd: 0, ign: 0};
        vecs[1] = '{name: "page_split",   base: 32'h0FC0, len: 32'd128,  accept: 1, nar: 2, nbeats: 32,  rnd: 0, ign: 0};
        vecs[2] = '{name: "max_bursts",   base: 32'h0000, len: 32'd2048, accept: 1, nar: 2, nbeats: 512, rnd: 0, ign: 0};
        vecs[3] = '{name: "bad_align",    base: 32'h0004, len: 32'd64,   accept: 0, nar: 0, nbeats: 0,   rnd: 0, ign: 0};
        vecs[4] = '{name: "bad_len",      base: 32'h0000, len: 32'd6,    accept: 0, nar: 0, nbeats: 0,   rnd: 0, ign: 0};
        vecs[5] = '{name: "zero_len",     base: 32'h0000, len: 32'd0,    accept: 0, nar: 0, nbeats: 0,   rnd: 0, ign: 0};
        vecs[6] = '{name: "rand_3burst",  base: 32'h0F00, len: 32'd1540, accept: 1, nar: 3, nbeats: 385, rnd: 1, ign: 1};
        vecs[7] = '{name: "one_beat",     base: 32'h0040, len: 32'd4,    accept: 1, nar: 1, nbeats: 1,   rnd: 1, ign: 0};

        for (int i = 0; i < 8; i++) run_job(vecs[i]);

        // Error response on beat 3: first burst drains, no second AR.
        rnd_mode = 0;
        err_beat = 2;
        ar_q.push_back('{addr: 32'h0, len: 8'd255});
        for (int i = 0; i < 256; i++) beat_q.push_back('{data: pat(32'(4 * i)), last: 1'b0});
        ar0 = n_ar_seen;
        b0  = n_beat_seen;
        pulse_start(32'h0, 32'd2048);
        finish_job("rresp_err", ar0, b0, 1, 256, 1'b1, 1'b0);
        err_beat = -1;

        // Reset in the middle of a burst with random back-pressure.
        rnd_mode = 1;
        model_job(32'h3000, 32'd2048);
        pulse_start(32'h3000, 32'd2048);
        repeat (60) begin
            @(posedge clk);
            #2;
        end
        chk("midrst_busy_before", 32'(o_busy), 32'd1);
        rst_n = 0;
        ar_q.delete();
        beat_q.delete();
        @(posedge clk);
        #2;
        chk("midrst_arvalid", 32'(m_axi_arvalid), 32'd0);
        chk("midrst_rready", 32'(m_axi_rready), 32'd0);
        chk("midrst_ovalid", 32'(o_valid), 32'd0);
        chk("midrst_olast", 32'(o_last), 32'd0);
        chk("midrst_done", 32'(o_done), 32'd0);
        chk("midrst_error", 32'(o_error), 32'd0);
        chk("midrst_busy", 32'(o_busy), 32'd0);
        chk("midrst_araddr", m_axi_araddr, 32'd0);
        chk("midrst_arlen", 32'(m_axi_arlen), 32'd0);
        rst_n = 1;
        @(posedge clk);
        #2;
        run_job('{name: "after_reset", base: 32'h1000, len: 32'd64, accept: 1, nar: 1, nbeats: 16, rnd: 1, ign: 0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_read_engine.md
DMA_READ_ENGINE -- requirements
Module: dma_read_engine

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, sets the AXI address width.
REQ-002 Parameter DATA_WIDTH, default 32, sets the AXI data width; only 32 is supported.
REQ-003 clk  in  1  single clock; all logic on the rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 i_start  in  1  one-cycle pulse that requests a job; sampled in IDLE only.
REQ-006 i_base_addr  in  ADDR_WIDTH  job start byte address.
REQ-007 i_total_len  in  32  job length in bytes.
REQ-008 o_busy  out  1  high in every state except IDLE.
REQ-009 o_done  out  1  one-cycle pulse when the job ends.
REQ-010 o_error  out  1  sticky error flag.
REQ-011 m_axi_araddr/arlen/arsize/arburst/arvalid  out  ADDR_WIDTH/8/3/2/1  AXI4 AR channel.
REQ-012 m_axi_arready  in  1  AXI4 AR channel ready.
REQ-013 m_axi_rdata/rresp/rlast/rvalid  in  DATA_WIDTH/2/1/1  AXI4 R channel inputs.
REQ-014 m_axi_rready  out  1  AXI4 R channel ready.
REQ-015 o_data/o_valid/o_last  out  DATA_WIDTH/1/1  stream output to the consumer.
REQ-016 i_ready  in  1  stream ready from the consumer.

Function
REQ-017 The FSM SHALL have states IDLE, CALC, AR_HANDSHAKE, R_BURST, DONE.
REQ-018 IDLE with i_start SHALL transition as follows:
- job accepted (i_base_addr[5:0]==0, i_total_len[1:0]==0, i_total_len!=0): load addr_reg/len_left_reg, clear o_error, go to CALC.
- otherwise: set o_error=1, stay in IDLE, load nothing.
REQ-019 bytes_this_burst SHALL be min(len_left_reg, 4096-addr_reg[11:0], 1024), computed in 13-bit unsigned arithmetic; no burst SHALL cross a 4 KB boundary.
REQ-020 CALC SHALL register araddr=addr_reg, arlen=bytes_this_burst/4-1, and the expected beat count; it SHALL go to AR_HANDSHAKE after 1 cycle.
REQ-021 In AR_HANDSHAKE, m_axi_arvalid SHALL be 1, with arsize=3'b010 and arburst=2'b01.
REQ-022 AR signals SHALL remain stable until arready, then go to R_BURST; arvalid SHALL be 0 in every other state.
REQ-023 In R_BURST, m_axi_rready SHALL equal i_ready; o_valid SHALL equal m_axi_rvalid; o_data SHALL equal m_axi_rdata (zero-latency pass-through).
- R_BURST SHALL not drop or duplicate beats under any rvalid/i_ready pattern.
REQ-024 An 8-bit beat counter SHALL clear on the AR handshake and increment on each R handshake.
REQ-025 The beat counter SHALL not wrap: a burst holds at most 256 beats.
REQ-026 o_last SHALL be 1 only on the final beat of the whole job (len_left_reg==bytes_this_burst and beat_cnt==arlen).
REQ-027 On the R handshake with beat_cnt==arlen:
- update addr_reg+=bytes_this_burst and len_left_reg-=bytes_this_burst;
- next state is DONE if len_left_reg becomes 0 or o_error==1, else CALC.
REQ-028 R-channel errors:
- rresp!=2'b00 on any beat SHALL set o_error.
- An rlast value that differs from (beat_cnt==arlen) SHALL set o_error.
- The current burst SHALL drain to its expected beat count; no further AR SHALL be issued.
REQ-029 DONE SHALL assert o_done for exactly 1 cycle, then go to IDLE.
REQ-030 i_start outside IDLE SHALL be ignored.
REQ-031 Simultaneous rvalid with i_ready=0 SHALL hold rready=0; the beat transfers on the first cycle both are high.

Reset
REQ-032 When rst_n=0 at a clock edge, the FSM SHALL enter IDLE on that edge, including mid-burst.
REQ-033 The same edge SHALL clear all counters and registers and set every output to 0: arvalid, rready, o_valid, o_last, o_done, o_error, o_busy, araddr, arlen.
REQ-034 The block SHALL not track outstanding AXI transactions across reset; the interconnect resets with it.

Verification
REQ-035 base 0x1000, len 64 -> one AR (araddr 0x1000, arlen 15), 16 beats, o_last on beat 16, o_done 1 cycle later, o_error 0.
REQ-036 base 0x0FC0, len 128 -> AR 0x0FC0 arlen 15, then AR 0x1000 arlen 15; 32 beats total; o_last only on beat 32.
REQ-037 base 0x0, len 2048 -> AR 0x000 arlen 255, then AR 0x400 arlen 255; o_done after beat 512.
REQ-038 base 0x0004 len 64, or base 0x0 len 6 -> o_error=1, o_busy stays 0, arvalid never asserted.
REQ-039 base 0x0, len 2048, rresp=2'b10 on beat 3 -> 256 beats drained, o_error=1, o_done pulse, no second AR.
REQ-040 i_ready toggled randomly and reset asserted mid-burst -> rready tracks i_ready, output sequence matches rdata exactly, and all outputs are 0 the cycle after reset.
